// File: rtl/wb_write_queue_pkg.sv
// Shared types and widths for the write-back queue in front of the 32x32 regfile.
package wb_write_queue_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Register 0 is hardwired in the regfile, so writes to it never occupy a slot.
  function automatic logic is_live(input logic [ADDR_WIDTH-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bundle of request, regfile-write and probe signals around the write-back queue.
interface wb_write_queue_if #(
  parameter int DEPTH = 4
);
  import wb_write_queue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic                  in_valid_a;
  logic [ADDR_WIDTH-1:0] in_register_a;
  logic [DATA_WIDTH-1:0] in_data_a;
  logic                  in_valid_b;
  logic [ADDR_WIDTH-1:0] in_register_b;
  logic [DATA_WIDTH-1:0] in_data_b;
  logic                  in_ready;

  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;

  logic [ADDR_WIDTH-1:0] probe_register1;
  logic [ADDR_WIDTH-1:0] probe_register2;
  logic                  pending1;
  logic                  pending2;
  logic [DATA_WIDTH-1:0] bypass_data1;
  logic [DATA_WIDTH-1:0] bypass_data2;

  logic [CW-1:0]         count;

  modport master (
    output in_valid_a, in_register_a, in_data_a,
    output in_valid_b, in_register_b, in_data_b,
    output probe_register1, probe_register2,
    input  in_ready, write_register, write_data, reg_write,
    input  pending1, pending2, bypass_data1, bypass_data2, count
  );

  modport slave (
    input  in_valid_a, in_register_a, in_data_a,
    input  in_valid_b, in_register_b, in_data_b,
    input  probe_register1, probe_register2,
    output in_ready, write_register, write_data, reg_write,
    output pending1, pending2, bypass_data1, bypass_data2, count
  );

endinterface

// File: rtl/wb_write_queue_probe_match.sv
// Youngest-wins search of the queued entries plus the output stage for one probe address.
module wb_probe_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wb_entry_t             entries [DEPTH],
  input  logic [PW-1:0]         head,
  input  logic [CW-1:0]         count,
  input  logic                  out_valid,
  input  wb_entry_t             out_entry,
  input  logic [ADDR_WIDTH-1:0] probe_addr,
  output logic                  pending,
  output logic [DATA_WIDTH-1:0] bypass_data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    pending     = 1'b0;
    bypass_data = '0;
    idx         = head;
    if (is_live(probe_addr)) begin
      if (out_valid && (out_entry.addr == probe_addr)) begin
        pending     = 1'b1;
        bypass_data = out_entry.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((i < int'(count)) && (entries[idx].addr == probe_addr)) begin
          pending     = 1'b1;
          bypass_data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Dual-port write-back FIFO retiring one regfile write per cycle, with two bypass probes.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  wb_write_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  wb_entry_t     out_entry;
  logic          out_valid;

  logic          in_ready;
  logic          enq_a;
  logic          enq_b;
  logic          pop;
  wb_entry_t     in_a;
  wb_entry_t     in_b;
  logic [PW-1:0] slot_b;

  assign in_a = '{addr: bus.in_register_a, data: bus.in_data_a};
  assign in_b = '{addr: bus.in_register_b, data: bus.in_data_b};

  // Ready only when two free slots remain, so a dual accept can never overflow.
  assign in_ready = (count <= CW'(DEPTH - 2));
  assign enq_a    = bus.in_valid_a & in_ready & is_live(bus.in_register_a);
  assign enq_b    = bus.in_valid_b & in_ready & is_live(bus.in_register_b);
  assign pop      = (count != '0);
  assign slot_b   = enq_a ? (tail + PW'(1)) : tail;

  always_ff @(posedge clk) begin
    if (enq_a) mem[tail]   <= in_a;
    if (enq_b) mem[slot_b] <= in_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_entry <= '0;
      out_valid <= 1'b0;
    end else begin
      tail  <= tail + PW'(enq_a) + PW'(enq_b);
      count <= count + CW'(enq_a) + CW'(enq_b) - CW'(pop);
      if (pop) begin
        out_entry <= mem[head];
        out_valid <= 1'b1;
        head      <= head + PW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  wb_probe_match #(.DEPTH(DEPTH)) u_probe1 (
    .entries     (mem),
    .head        (head),
    .count       (count),
    .out_valid   (out_valid),
    .out_entry   (out_entry),
    .probe_addr  (bus.probe_register1),
    .pending     (bus.pending1),
    .bypass_data (bus.bypass_data1)
  );

  wb_probe_match #(.DEPTH(DEPTH)) u_probe2 (
    .entries     (mem),
    .head        (head),
    .count       (count),
    .out_valid   (out_valid),
    .out_entry   (out_entry),
    .probe_addr  (bus.probe_register2),
    .pending     (bus.pending2),
    .bypass_data (bus.bypass_data2)
  );

  assign bus.in_ready       = in_ready;
  assign bus.count          = count;
  assign bus.reg_write      = out_valid;
  assign bus.write_register = out_entry.addr;
  assign bus.write_data     = out_entry.data;

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back buffer that sits directly upstream of the 32x32 register file and drives its single write port (WriteRegister, WriteData, RegWrite).
- Accepts up to two write-back requests per cycle: port A from the ALU, port B from the load unit.
- Queues requests in a small FIFO and retires one per cycle, in program order.
- Provides two probe ports: the decode stage can detect writes still pending for a register and take bypass data from them.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width.

Ports:
- Clk  input  1  clock, posedge.
- Reset  input  1  asynchronous, active-high reset.
- InValidA  input  1  port A request valid.
- InRegisterA  input  ADDR_WIDTH  port A destination register.
- InDataA  input  DATA_WIDTH  port A data.
- InValidB  input  1  port B request valid; B is younger than A.
- InRegisterB  input  ADDR_WIDTH  port B destination register.
- InDataB  input  DATA_WIDTH  port B data.
- InReady  output  1  both ports may enqueue this cycle.
- WriteRegister  output  ADDR_WIDTH  to regfile.
- WriteData  output  DATA_WIDTH  to regfile.
- RegWrite  output  1  to regfile write enable.
- ProbeRegister1  input  ADDR_WIDTH  probe address 1.
- ProbeRegister2  input  ADDR_WIDTH  probe address 2.
- Pending1  output  1  a write to ProbeRegister1 is not yet committed.
- Pending2  output  1  a write to ProbeRegister2 is not yet committed.
- BypassData1  output  DATA_WIDTH  youngest pending data for ProbeRegister1.
- BypassData2  output  DATA_WIDTH  youngest pending data for ProbeRegister2.
- Count  output  clog2(DEPTH+1)  FIFO occupancy, excluding the output stage.

Behaviour:
- Reset (async, any time, including mid-drain):
  - Count=0, pointers=0, RegWrite=0, WriteRegister=0, WriteData=0.
  - All queued entries are discarded.
  - Outputs take reset values immediately, without waiting for Clk.
- Ready and accept:
  - InReady = (Count <= DEPTH-2), combinational from registered Count only.
  - A port is accepted at posedge Clk when its InValid=1 and InReady=1.
  - When InReady=0, inputs are ignored; no entry is lost or overwritten.
- Register 0: an accepted request with InRegister=0 completes its handshake but is not enqueued.
- Enqueue order at one edge: A then B. Count rises by the number of non-zero-register accepts.
- Drain, one per edge:
  - If Count>0 before the edge: pop head into WriteRegister/WriteData, RegWrite<=1, Count-=1.
  - Otherwise RegWrite<=0.
  - An entry enqueued at edge N is popped no earlier than edge N+1. The regfile commits it at edge N+2 or later.
  - RegWrite is high for exactly one cycle per entry.
- Simultaneous enqueue and pop at the same edge: Count_next = Count + enq - pop.
- Pointers wrap modulo DEPTH.
- Probe logic, combinational from registered state only (in-flight inputs are not probed):
  - Searched: all FIFO entries, plus the output stage when RegWrite=1.
  - Youngest match wins; order is tail-1 down to head, then the output stage.
  - No match: Pending=0, BypassData=0.
  - Probe of register 0: always Pending=0, BypassData=0.
- Arithmetic: no data transformation. Count never exceeds DEPTH.

Decomposition:
- Shared package holds:
  - ADDR_WIDTH, DATA_WIDTH;
  - REG_ZERO = 5'd0;
  - wb_entry struct {reg addr, data}.
- One sub-module, wb_probe_match: priority search of the FIFO plus output stage for one probe address. Instantiated twice.

Test Plan:
- Reset: assert Reset mid-cycle -> RegWrite=0, Count=0, InReady=1, Pending1/2=0 immediately.
- Single write, with ProbeRegister1=5:
  - Stimulus: A writes reg 5 = 0xDEADBEEF at edge N.
  - After edge N: Pending1=1, BypassData1=0xDEADBEEF.
  - After edge N+1: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF for one cycle.
  - After edge N+2: Pending1=0.
- Same-edge ordering: A reg 3 = 0x11 and B reg 3 = 0x22 at one edge.
  - Probe 3 -> BypassData=0x22.
  - Commits: reg 3 <- 0x11, then reg 3 <- 0x22 on consecutive cycles.
- Register 0: A reg 0 = 0xFF and B reg 9 = 0x99.
  - Exactly one RegWrite pulse, with reg 9 = 0x99.
  - Count peaks at 1.
  - Probe 0 -> Pending=0.
- Fill with DEPTH=4: hold both valids high, distinct registers each cycle.
  - Count sequence 2, 3.
  - InReady=0 while Count=3.
  - All accepted entries commit in order, with no loss or duplication.
- Reset mid-drain: at Count=3, pulse Reset.
  - No further RegWrite pulses.
  - Count=0; a subsequent write behaves as in the single-write scenario.
